bs_arbtr_rtr_gen2: RTL and testbench

//  Next-generation bus generator/arbiter. It serves DRVRS driver FIFOs: one packet per transaction is

---
 rtl/bs_arbtr_rtr_gen2.sv | 150 +++++++++++++++
 tb/tb_bs_arbtr_rtr_gen2.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_arbtr_rtr_gen2.sv
// Bus arbiter/router: grants one driver FIFO, pops one packet, routes it to one or all other receivers.
// Latency: grant (pop) one cycle after pndng seen in IDLE; push one cycle after pop when unblocked.
// Backpressure: waits while any target receiver is full (all-or-nothing), drops after TIMEOUT cycles.
module bs_arbtr_rtr_gen2 #(
  parameter int PCKG_SZ = 16,
  parameter int DRVRS = 8,
  parameter int ID_W = 8,
  parameter logic [ID_W-1:0] BCAST = 8'hFF,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]           pop,
  input  logic [DRVRS-1:0]           full,
  output logic [DRVRS-1:0]           push,
  output logic [PCKG_SZ-1:0]         D_push,
  output logic [$clog2(DRVRS)-1:0]   grant_id,
  output logic                       busy,
  output logic                       err,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int GW = $clog2(DRVRS);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [DRVRS-1:0] ONE = {{(DRVRS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, DELIVER} state_t;

  state_t              state_q, state_d;
  logic [PCKG_SZ-1:0]  pkt;
  logic [GW-1:0]       ptr;
  logic [WC_W-1:0]     wait_cnt;
  logic [GW-1:0]       sel;
  logic [GW-1:0]       cand;
  logic                found;
  logic [ID_W-1:0]     dest;
  logic [DRVRS-1:0]    mask;
  logic                illegal;
  logic                blocked;
  logic                timed_out;

  // Arbitration: round-robin from ptr+1 with wrap, or lowest pending index in fixed-priority mode.
  always_comb begin
    sel = '0;
    cand = '0;
    found = 1'b0;
    if (ARB_MODE == 1) begin
      for (int i = 0; i < DRVRS; i++) begin
        if (!found && pndng[i]) begin
          sel = GW'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 1; i <= DRVRS; i++) begin
        cand = GW'((int'(ptr) + i) % DRVRS);
        if (!found && pndng[cand]) begin
          sel = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Destination decode: broadcast excludes the source; out-of-range or self-addressed IDs are illegal.
  always_comb begin
    dest = pkt[PCKG_SZ-1 -: ID_W];
    mask = '0;
    illegal = 1'b0;
    if (dest == BCAST) begin
      mask = ~(ONE << grant_id);
    end else if ((int'(dest) < DRVRS) && (int'(dest) != int'(grant_id))) begin
      mask = ONE << dest;
    end else begin
      illegal = 1'b1;
    end
  end

  assign blocked = |(mask & full);
  assign timed_out = (wait_cnt == WC_W'(TIMEOUT - 1));

  // Next-state: leave DELIVER on delivery, illegal ID or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pndng) state_d = DELIVER;
      DELIVER: if (illegal || !blocked || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs; pop/push/err default low so they pulse for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt      <= '0;
      ptr      <= GW'(DRVRS - 1);
      wait_cnt <= '0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pop  <= '0;
      push <= '0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|pndng) begin
            pkt      <= D_pop[sel*PCKG_SZ +: PCKG_SZ];
            pop      <= ONE << sel;
            grant_id <= sel;
            busy     <= 1'b1;
            wait_cnt <= '0;
            if (ARB_MODE == 0) ptr <= sel;
          end
        end
        DELIVER: begin
          if (illegal || (blocked && timed_out)) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            wait_cnt <= '0;
            if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
          end else if (!blocked) begin
            push     <= mask;
            D_push   <= pkt;
            busy     <= 1'b0;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_arbtr_rtr_gen2.sv
// Directed bench for bs_arbtr_rtr_gen2: unicast, broadcast, fairness, back-pressure, illegal IDs, reset.
// A second instance in fixed-priority mode shares the inputs for the arbitration comparison.
// Inputs are driven and outputs sampled on the falling edge.
module tb_bs_arbtr_rtr_gen2;

  logic             clk;
  logic             reset;
  logic [7:0]       pndng;
  logic [7:0][15:0] dpop;
  logic [7:0]       full;
  logic [7:0]       pop, push;
  logic [15:0]      d_push;
  logic [2:0]       grant_id;
  logic             busy, err;
  logic [15:0]      drop_cnt;
  logic [7:0]       fp_pop, fp_push;
  logic [15:0]      fp_d_push;
  logic [2:0]       fp_grant_id;
  logic             fp_busy, fp_err;
  logic [15:0]      fp_drop_cnt;

  int n_checks = 0;
  int n_fail = 0;

  bs_arbtr_rtr_gen2 #(.ARB_MODE(0)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(dpop), .pop(pop), .full(full),
    .push(push), .D_push(d_push), .grant_id(grant_id), .busy(busy), .err(err), .drop_cnt(drop_cnt)
  );

  bs_arbtr_rtr_gen2 #(.ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(dpop), .pop(fp_pop), .full(full),
    .push(fp_push), .D_push(fp_d_push), .grant_id(fp_grant_id), .busy(fp_busy), .err(fp_err),
    .drop_cnt(fp_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    pndng = '0;
    full = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pop, push, d_push, grant_id, busy, err, drop_cnt} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pop=%h push=%h d_push=%h gid=%0d busy=%b err=%b drop=%0d, expected all zero",
               pop, push, d_push, grant_id, busy, err, drop_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unicast();
    dpop[2] = 16'h0555;
    pndng = 8'h04;
    @(negedge clk);
    pndng = '0;
    n_checks++;
    if (pop !== 8'h04 || grant_id !== 3'd2 || busy !== 1'b1 || push !== 8'h00) begin
      n_fail++;
      $display("FAIL uni_pop: got pop=%h gid=%0d busy=%b push=%h, expected pop=04 gid=2 busy=1 push=00",
               pop, grant_id, busy, push);
    end
    @(negedge clk);
    n_checks++;
    if (push !== 8'h20 || d_push !== 16'h0555 || pop !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL uni_push: got push=%h d_push=%h pop=%h busy=%b err=%b, expected push=20 d_push=0555 pop=00 busy=0 err=0",
               push, d_push, pop, busy, err);
    end
    @(negedge clk);
    n_checks++;
    if (push !== 8'h00 || d_push !== 16'h0555) begin
      n_fail++;
      $display("FAIL uni_pulse: got push=%h d_push=%h, expected push=00 d_push=0555", push, d_push);
    end
  endtask

  task automatic test_broadcast();
    dpop[3] = 16'hFFAB;
    full = '0;
    pndng = 8'h08;
    @(negedge clk);
    pndng = '0;
    n_checks++;
    if (pop !== 8'h08 || grant_id !== 3'd3) begin
      n_fail++;
      $display("FAIL bc_pop: got pop=%h gid=%0d, expected pop=08 gid=3", pop, grant_id);
    end
    @(negedge clk);
    n_checks++;
    if (push !== 8'hF7 || d_push !== 16'hFFAB || err !== 1'b0) begin
      n_fail++;
      $display("FAIL bc_push: got push=%h d_push=%h err=%b, expected push=F7 d_push=FFAB err=0",
               push, d_push, err);
    end
    @(negedge clk);
    n_checks++;
    if (push !== 8'h00) begin
      n_fail++;
      $display("FAIL bc_once: got push=%h, expected 00", push);
    end
  endtask

  task automatic test_rr_fairness();
    logic [2:0] exp_g;
    logic [2:0] exp_d;
    for (int d = 0; d < 8; d++) dpop[d] = {5'd0, 3'((d + 1) % 8), 8'(d)};
    full = '0;
    pndng = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      exp_g = 3'(k % 8);
      exp_d = 3'((k + 1) % 8);
      @(negedge clk);
      n_checks++;
      if (grant_id !== exp_g || pop !== (8'h01 << exp_g)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got gid=%0d pop=%h, expected gid=%0d pop=%h",
                 k, grant_id, pop, exp_g, 8'h01 << exp_g);
      end
      n_checks++;
      if (fp_grant_id !== 3'd0 || fp_pop !== 8'h01) begin
        n_fail++;
        $display("FAIL fp_grant[%0d]: got gid=%0d pop=%h, expected gid=0 pop=01", k, fp_grant_id, fp_pop);
      end
      @(negedge clk);
      if (k == 15) pndng = '0;
      n_checks++;
      if (push !== (8'h01 << exp_d)) begin
        n_fail++;
        $display("FAIL rr_push[%0d]: got push=%h, expected %h", k, push, 8'h01 << exp_d);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int pushes;
    int errs;
    int err_at;
    dpop[0] = 16'h01C3;
    full = 8'h02;
    pndng = 8'h01;
    @(negedge clk);
    pndng = '0;
    n_checks++;
    if (pop !== 8'h01 || push !== 8'h00) begin
      n_fail++;
      $display("FAIL bp_pop: got pop=%h push=%h, expected pop=01 push=00", pop, push);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (push !== 8'h00 || busy !== 1'b1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got push=%h busy=%b err=%b, expected push=00 busy=1 err=0",
                 c, push, busy, err);
      end
    end
    full = 8'h00;
    @(negedge clk);
    n_checks++;
    if (push !== 8'h02 || d_push !== 16'h01C3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got push=%h d_push=%h busy=%b, expected push=02 d_push=01C3 busy=0",
               push, d_push, busy);
    end
    @(negedge clk);
    // Held full: the packet waits out the timeout and is dropped.
    dpop[0] = 16'h0177;
    full = 8'h02;
    pndng = 8'h01;
    @(negedge clk);
    pndng = '0;
    pushes = 0;
    errs = 0;
    err_at = -1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (push !== 8'h00) pushes++;
      if (err === 1'b1) begin
        errs++;
        if (err_at < 0) err_at = c;
      end
    end
    full = '0;
    n_checks++;
    if (err_at !== 16 || errs !== 1) begin
      n_fail++;
      $display("FAIL bp_timeout: got err first at cycle %0d with %0d pulses, expected cycle 16 with 1 pulse",
               err_at, errs);
    end
    n_checks++;
    if (pushes !== 0 || drop_cnt !== 16'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drop: got pushes=%0d drop_cnt=%0d busy=%b, expected 0, 1, 0", pushes, drop_cnt, busy);
    end
  endtask

  task automatic test_illegal_ids();
    logic [15:0] ids [2];
    int pushes;
    ids[0] = 16'h0911;
    ids[1] = 16'h0422;
    pushes = 0;
    test_reset();
    for (int k = 0; k < 2; k++) begin
      dpop[4] = ids[k];
      pndng = 8'h10;
      @(negedge clk);
      pndng = '0;
      if (push !== 8'h00) pushes++;
      n_checks++;
      if (pop !== 8'h10 || grant_id !== 3'd4) begin
        n_fail++;
        $display("FAIL ill_pop[%0d]: got pop=%h gid=%0d, expected pop=10 gid=4", k, pop, grant_id);
      end
      @(negedge clk);
      if (push !== 8'h00) pushes++;
      n_checks++;
      if (err !== 1'b1 || drop_cnt !== 16'(k + 1)) begin
        n_fail++;
        $display("FAIL ill_err[%0d]: got err=%b drop_cnt=%0d, expected err=1 drop_cnt=%0d", k, err, drop_cnt, k + 1);
      end
      @(negedge clk);
      if (push !== 8'h00) pushes++;
      n_checks++;
      if (err !== 1'b0) begin
        n_fail++;
        $display("FAIL ill_pulse[%0d]: got err=%b, expected 0", k, err);
      end
    end
    n_checks++;
    if (pushes !== 0) begin
      n_fail++;
      $display("FAIL ill_nopush: got %0d push cycles, expected 0", pushes);
    end
  endtask

  task automatic test_reset_in_deliver();
    int pushes;
    dpop[5] = 16'h06AA;
    dpop[0] = 16'h0100;
    full = 8'h40;
    pndng = 8'h20;
    @(negedge clk);
    pndng = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || grant_id !== 3'd5) begin
      n_fail++;
      $display("FAIL rst_wait: got busy=%b gid=%0d, expected busy=1 gid=5", busy, grant_id);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({pop, push, d_push, grant_id, busy, err, drop_cnt} !== 50'd0) begin
      n_fail++;
      $display("FAIL rst_async: got pop=%h push=%h d_push=%h gid=%0d busy=%b err=%b drop=%0d, expected all zero",
               pop, push, d_push, grant_id, busy, err, drop_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    full = '0;
    pushes = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (push !== 8'h00 || busy !== 1'b0) pushes++;
    end
    n_checks++;
    if (pushes !== 0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_quiet: got %0d active cycles drop_cnt=%0d, expected 0 and 0", pushes, drop_cnt);
    end
    pndng = 8'h21;
    @(negedge clk);
    pndng = '0;
    n_checks++;
    if (grant_id !== 3'd0 || pop !== 8'h01) begin
      n_fail++;
      $display("FAIL rst_first_grant: got gid=%0d pop=%h, expected gid=0 pop=01", grant_id, pop);
    end
    @(negedge clk);
    n_checks++;
    if (push !== 8'h02 || d_push !== 16'h0100) begin
      n_fail++;
      $display("FAIL rst_first_push: got push=%h d_push=%h, expected push=02 d_push=0100", push, d_push);
    end
  endtask

  initial begin
    reset = 1'b1;
    pndng = '0;
    full = '0;
    dpop = '0;
    test_reset();
    test_unicast();
    test_broadcast();
    test_reset();
    test_rr_fairness();
    test_backpressure();
    test_illegal_ids();
    test_reset_in_deliver();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
